alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Arm/disarm state machine for the security system.
- Watches door/zone sensors and the keypad code switches.
- Drives `aux`, the level that the downstream LED alarm blinker consumes (aux=1: blink; aux=0: LEDs steady).
- Implements exit delay, entry delay, and a bad-code counter that trips the alarm.

Parameters:
- NUM_SENSORS, 4, number of sensor inputs; bit 0 is the entry door, the other bits are instant zones.
- EXIT_CYCLES, 500_000_000, exit delay length in clk cycles (10 s at 50 MHz); min 2.
- ENTRY_CYCLES, 250_000_000, entry delay length in clk cycles (5 s at 50 MHz); min 2.
- CODE, 4'b1010, disarm code compared against code_sw.
- MAX_TRIES, 3, wrong-code count that forces ALARM; range 1..3.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- arm_btn  in  1  raw arm request, active-high, asynchronous to clk
- code_sw  in  4  raw keypad code switches
- code_enter  in  1  raw code-submit button, active-high
- sensors  in  NUM_SENSORS  raw sensor levels, 1 = tripped
- aux  out  1  alarm active, feeds the LED blinker
- armed  out  1  high in EXIT_DELAY, ARMED, ENTRY_DELAY and ALARM
- state  out  3  current state code, for debug display
- bad_cnt  out  2  wrong-code count, saturating at MAX_TRIES

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=DISARMED(0); aux=0, armed=0, bad_cnt=0.
  - Delay counter and all synchronizer flops are cleared.
  - Applies immediately, including mid-delay or mid-alarm.
  - Release is sampled on clk.
- Input conditioning:
  - arm_btn, code_enter and sensors each pass through 2 flip-flop synchronizers.
  - arm_btn and code_enter feed a rising-edge detector (sync2 & ~sync3), which gives a one-cycle event.
  - code_sw is sampled only on the code_enter event; it is quasi-static, so a single register stage is enough.
  - Timing: a raw input that rises before clk edge k produces a state change at edge k+2. A held button produces exactly one event.
- Code check: on a code_enter event, valid = (code_sw == CODE); otherwise the event is invalid.
- States:
  - 0 DISARMED
  - 1 EXIT_DELAY
  - 2 ARMED
  - 3 ENTRY_DELAY
  - 4 ALARM
  - Codes 5–7 are illegal and go to DISARMED on the next clk.
- DISARMED:
  - arm event with all synced sensors = 0 → EXIT_DELAY; counter loads EXIT_CYCLES-1.
  - arm event with any sensor = 1 is ignored.
  - Code events are ignored and bad_cnt holds 0.
- EXIT_DELAY:
  - Counter decrements each cycle; the state lasts exactly EXIT_CYCLES cycles, then → ARMED.
  - Sensors are ignored.
  - A valid code → DISARMED (cancel).
- ARMED:
  - sensors[0] = 1 → ENTRY_DELAY; counter loads ENTRY_CYCLES-1.
  - Any other sensor bit = 1 → ALARM.
  - If both happen in the same cycle, ALARM wins.
  - A valid code → DISARMED.
- ENTRY_DELAY:
  - The state lasts exactly ENTRY_CYCLES cycles, then → ALARM.
  - A non-door sensor → ALARM immediately.
  - A valid code → DISARMED.
- ALARM:
  - Held until a valid code arrives → DISARMED.
  - Sensors are ignored.
- Bad-code counter:
  - In states 1–4, an invalid code increments bad_cnt, saturating at MAX_TRIES.
  - If the increment reaches MAX_TRIES in states 1–3, next state = ALARM.
  - bad_cnt clears on every entry to DISARMED.
- Arm events outside DISARMED are ignored.
- Priority in one cycle: valid code > instant-zone sensor > delay expiry / door sensor.
  - Example: a valid code in the final ENTRY_DELAY cycle → DISARMED, not ALARM.
- Outputs are registered decodes of state and update in the same cycle as state:
  - aux = (state == ALARM).
  - armed = (state != DISARMED).
- Counter width is $clog2(max(EXIT_CYCLES, ENTRY_CYCLES)) bits; it never wraps because it is reloaded on every delay-state entry.

Test Plan (EXIT_CYCLES=8, ENTRY_CYCLES=6, CODE=4'hA, MAX_TRIES=3, NUM_SENSORS=4):
- Pulse arm_btn with sensors=0 → state=1 two edges later, armed=1; state=2 exactly 8 cycles after entering 1; aux=0 throughout.
- In ARMED set sensors=4'b0001 → state=3; hold, no code → state=4 and aux=1 exactly 6 cycles later; then code_sw=A + code_enter → state=0, aux=0, bad_cnt=0.
- In ARMED set sensors=4'b0100 → state=4 on the 3rd edge after the change, with no entry delay; sensors=4'b0011 at once → ALARM.
- In ENTRY_DELAY enter code 4'h3 three times → bad_cnt 1, 2, 3 and state=4 on the third event; further wrong codes keep bad_cnt=3.
- Arm with sensors=4'b0010 → arm ignored, state stays 0; valid code event timed to land in the last ENTRY_DELAY cycle → state=0, aux never asserts.
- Assert rst_n=0 while in ALARM mid-cycle → aux=0, state=0 immediately (before the next clk); a held arm_btn across reset release produces no arm event.

Source files
------------

// File: rtl/alarm_controller.sv
// Security-system arm/disarm controller with exit/entry delays and a bad-code lockout.
// Raw inputs are synchronised here; aux/armed are registered decodes of the next state.
module alarm_controller #(
  parameter int unsigned NUM_SENSORS  = 4,
  parameter int unsigned EXIT_CYCLES  = 500_000_000,
  parameter int unsigned ENTRY_CYCLES = 250_000_000,
  parameter logic [3:0]  CODE         = 4'b1010,
  parameter int unsigned MAX_TRIES    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm_btn,
  input  logic [3:0]             code_sw,
  input  logic                   code_enter,
  input  logic [NUM_SENSORS-1:0] sensors,
  output logic                   aux,
  output logic                   armed,
  output logic [2:0]             state,
  output logic [1:0]             bad_cnt
);

  localparam int unsigned MaxCycles = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles);

  localparam logic [CntW-1:0]        ExitLoad  = CntW'(EXIT_CYCLES - 1);
  localparam logic [CntW-1:0]        EntryLoad = CntW'(ENTRY_CYCLES - 1);
  localparam logic [1:0]             MaxTries  = 2'(MAX_TRIES);
  localparam logic [NUM_SENSORS-1:0] ZoneMask  = ~NUM_SENSORS'(1);

  typedef enum logic [2:0] {
    StDisarmed   = 3'd0,
    StExitDelay  = 3'd1,
    StArmed      = 3'd2,
    StEntryDelay = 3'd3,
    StAlarm      = 3'd4
  } state_e;

  // Synchroniser chains: bit 0 is the first stage, bit 2 the edge-detect history.
  logic [2:0]             arm_sync_q, enter_sync_q;
  logic [NUM_SENSORS-1:0] sens_s1_q, sens_s2_q;
  logic [3:0]             code_q;
  logic [2:0]             rdy_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      bad_cnt_q, bad_cnt_d;
  logic            aux_q, armed_q;

  logic       arm_ev, enter_ev, code_valid, code_bad, tripped;
  logic       instant_zone, door, any_sensor, delay_done;
  logic [1:0] bad_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_sync_q   <= '0;
      enter_sync_q <= '0;
      sens_s1_q    <= '0;
      sens_s2_q    <= '0;
      code_q       <= '0;
      rdy_q        <= '0;
    end else begin
      arm_sync_q   <= {arm_sync_q[1:0], arm_btn};
      enter_sync_q <= {enter_sync_q[1:0], code_enter};
      sens_s1_q    <= sensors;
      sens_s2_q    <= sens_s1_q;
      code_q       <= code_sw;
      rdy_q        <= {rdy_q[1:0], 1'b1};
    end
  end

  // Edges are ignored until the chain holds real samples, so a button held
  // through reset release does not look like a fresh press.
  assign arm_ev   = arm_sync_q[1] & ~arm_sync_q[2] & rdy_q[2];
  assign enter_ev = enter_sync_q[1] & ~enter_sync_q[2] & rdy_q[2];

  assign code_valid   = enter_ev && (code_q == CODE);
  assign code_bad     = enter_ev && (code_q != CODE);
  assign bad_inc      = (bad_cnt_q < MaxTries) ? bad_cnt_q + 2'd1 : bad_cnt_q;
  assign tripped      = code_bad && (bad_inc == MaxTries);
  assign instant_zone = |(sens_s2_q & ZoneMask);
  assign door         = sens_s2_q[0];
  assign any_sensor   = |sens_s2_q;
  assign delay_done   = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bad_cnt_d = bad_cnt_q;

    if (state_q != StDisarmed && code_bad) begin
      bad_cnt_d = bad_inc;
    end

    case (state_q)
      StDisarmed: begin
        if (arm_ev && !any_sensor) begin
          state_d = StExitDelay;
          cnt_d   = ExitLoad;
        end
      end
      StExitDelay: begin
        if (code_valid) begin
          state_d = StDisarmed;
        end else if (tripped) begin
          state_d = StAlarm;
        end else if (delay_done) begin
          state_d = StArmed;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StArmed: begin
        if (code_valid) begin
          state_d = StDisarmed;
        end else if (tripped || instant_zone) begin
          state_d = StAlarm;
        end else if (door) begin
          state_d = StEntryDelay;
          cnt_d   = EntryLoad;
        end
      end
      StEntryDelay: begin
        if (code_valid) begin
          state_d = StDisarmed;
        end else if (tripped || instant_zone || delay_done) begin
          state_d = StAlarm;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAlarm: begin
        if (code_valid) begin
          state_d = StDisarmed;
        end
      end
      default: state_d = StDisarmed;
    endcase

    if (state_d == StDisarmed) begin
      bad_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StDisarmed;
      cnt_q     <= '0;
      bad_cnt_q <= '0;
      aux_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bad_cnt_q <= bad_cnt_d;
      aux_q     <= (state_d == StAlarm);
      armed_q   <= (state_d != StDisarmed);
    end
  end

  assign aux     = aux_q;
  assign armed   = armed_q;
  assign state   = state_q;
  assign bad_cnt = bad_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios then random stimulus, all checked
// every cycle against a timestamp-based reference model of the arm/disarm rules.
module tb_alarm_controller;

  localparam int         EXIT  = 8;
  localparam int         ENTRY = 6;
  localparam int         MAXT  = 3;
  localparam logic [3:0] GOOD  = 4'hA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm_btn = 1'b0;
  logic       code_enter = 1'b0;
  logic [3:0] code_sw = '0;
  logic [3:0] sensors = '0;
  logic       aux, armed;
  logic [2:0] state;
  logic [1:0] bad_cnt;

  alarm_controller #(
    .NUM_SENSORS (4),
    .EXIT_CYCLES (EXIT),
    .ENTRY_CYCLES(ENTRY),
    .CODE        (GOOD),
    .MAX_TRIES   (MAXT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm_btn   (arm_btn),
    .code_sw   (code_sw),
    .code_enter(code_enter),
    .sensors   (sensors),
    .aux       (aux),
    .armed     (armed),
    .state     (state),
    .bad_cnt   (bad_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: state number, bad count, cycle of delay-state entry.
  int         m_st, m_bad, m_enter_t, m_t, since_rst;
  logic       arm_h [4];
  logic       ent_h [4];
  logic [3:0] sens_h[4];
  logic [3:0] code_h[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_bad = 0; m_enter_t = 0; m_t = 0; since_rst = 0;
    for (int i = 0; i < 4; i++) begin
      arm_h[i] = 1'b0; ent_h[i] = 1'b0; sens_h[i] = '0; code_h[i] = '0;
    end
  endtask

  // A raw level seen at edge t acts at edge t+2; code value is the one seen at t-1.
  task automatic model_step();
    logic arm_ev, ent_ev, valid, wrong, instant, door, trip;
    logic [3:0] sens, code;
    for (int i = 3; i > 0; i--) begin
      arm_h[i] = arm_h[i-1]; ent_h[i] = ent_h[i-1];
      sens_h[i] = sens_h[i-1]; code_h[i] = code_h[i-1];
    end
    arm_h[0] = arm_btn; ent_h[0] = code_enter; sens_h[0] = sensors; code_h[0] = code_sw;
    since_rst++;
    m_t++;
    arm_ev  = (since_rst >= 4) && arm_h[2] && !arm_h[3];
    ent_ev  = (since_rst >= 4) && ent_h[2] && !ent_h[3];
    sens    = sens_h[2];
    code    = code_h[1];
    valid   = ent_ev && (code == GOOD);
    wrong   = ent_ev && (code != GOOD);
    instant = |sens[3:1];
    door    = sens[0];
    trip    = 1'b0;
    if (m_st != 0 && wrong) begin
      if (m_bad < MAXT) m_bad++;
      trip = (m_bad == MAXT);
    end
    case (m_st)
      0: if (arm_ev && sens == 4'h0) begin m_st = 1; m_enter_t = m_t; end
      1: if (valid) m_st = 0;
         else if (trip) m_st = 4;
         else if (m_t - m_enter_t == EXIT) m_st = 2;
      2: if (valid) m_st = 0;
         else if (trip || instant) m_st = 4;
         else if (door) begin m_st = 3; m_enter_t = m_t; end
      3: if (valid) m_st = 0;
         else if (trip || instant || (m_t - m_enter_t == ENTRY)) m_st = 4;
      4: if (valid) m_st = 0;
      default: m_st = 0;
    endcase
    if (m_st == 0) m_bad = 0;
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_st));
    check("aux", 32'(aux), 32'(m_st == 4));
    check("armed", 32'(armed), 32'(m_st != 0));
    check("bad_cnt", 32'(bad_cnt), 32'(m_bad));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic press_arm();
    arm_btn = 1'b1; tick();
    arm_btn = 1'b0; tick(); tick();
  endtask

  task automatic press_code(input logic [3:0] v);
    code_sw = v; code_enter = 1'b1; tick();
    code_enter = 1'b0; tick(); tick();
  endtask

  task automatic arm_fully();
    press_arm();
    repeat (EXIT) tick();
    check("armed_reached", 32'(state), 32'd2);
  endtask

  initial begin
    int n;
    int unsigned r;
    model_reset();
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_aux", 32'(aux), 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Arm, then measure exit delay length.
    press_arm();
    check("exit_entered", 32'(state), 32'd1);
    check("exit_armed", 32'(armed), 32'd1);
    n = 0;
    while (state == 3'd1 && n < 20) begin tick(); n++; end
    check("exit_len", 32'(n), 32'(EXIT));
    check("after_exit", 32'(state), 32'd2);

    // Door opens, entry delay expires into alarm, then disarm.
    sensors = 4'b0001;
    tick(); tick(); tick();
    check("entry_entered", 32'(state), 32'd3);
    n = 0;
    while (state == 3'd3 && n < 20) begin tick(); n++; end
    check("entry_len", 32'(n), 32'(ENTRY));
    check("entry_alarm_aux", 32'(aux), 32'd1);
    sensors = 4'b0000;
    press_code(GOOD);
    check("disarm_state", 32'(state), 32'd0);
    check("disarm_aux", 32'(aux), 32'd0);

    // Instant zone: alarm on the third edge, no entry delay.
    arm_fully();
    sensors = 4'b0100;
    tick(); tick();
    check("zone_not_yet", 32'(state), 32'd2);
    tick();
    check("zone_alarm", 32'(state), 32'd4);
    sensors = 4'b0000;
    press_code(GOOD);
    arm_fully();
    sensors = 4'b0011;
    tick(); tick(); tick();
    check("door_and_zone", 32'(state), 32'd4);
    sensors = 4'b0000;
    press_code(GOOD);

    // Three wrong codes inside entry delay trip the alarm before expiry.
    arm_fully();
    sensors = 4'b0001;
    tick();
    for (int i = 0; i < 3; i++) begin
      code_sw = 4'h3; code_enter = 1'b1; tick();
      code_enter = 1'b0; tick();
    end
    check("two_bad_state", 32'(state), 32'd3);
    check("two_bad_cnt", 32'(bad_cnt), 32'd2);
    tick();
    check("three_bad_state", 32'(state), 32'd4);
    check("three_bad_cnt", 32'(bad_cnt), 32'd3);
    press_code(4'h3);
    check("bad_saturate", 32'(bad_cnt), 32'd3);
    sensors = 4'b0000;
    press_code(GOOD);

    // Arm refused with a tripped sensor.
    sensors = 4'b0010;
    press_arm();
    tick();
    check("arm_refused", 32'(state), 32'd0);
    sensors = 4'b0000;

    // Valid code landing in the last entry-delay cycle wins.
    arm_fully();
    sensors = 4'b0001;
    tick(); tick(); tick();
    check("late_entry", 32'(state), 32'd3);
    tick(); tick(); tick();
    code_sw = GOOD; code_enter = 1'b1;
    tick(); tick();
    check("late_still_entry", 32'(state), 32'd3);
    tick();
    check("late_disarm", 32'(state), 32'd0);
    check("late_aux", 32'(aux), 32'd0);
    code_enter = 1'b0;
    sensors = 4'b0000;
    tick();

    // Asynchronous reset mid-alarm; held arm across release is not an event.
    arm_fully();
    sensors = 4'b1000;
    tick(); tick(); tick();
    check("pre_reset_alarm", 32'(state), 32'd4);
    sensors = 4'b0000;
    arm_btn = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick(); tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("held_arm_ignored", 32'(state), 32'd0);
    arm_btn = 1'b0;
    tick();

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if (r % 40 == 0) sensors = 4'($urandom) & ((($urandom % 2) != 0) ? 4'h1 : 4'hF);
      else if (r % 9 == 0) sensors = 4'h0;
      if ((r >> 8) % 23 == 0) arm_btn = ~arm_btn;
      if (!code_enter && (r >> 16) % 17 == 0) begin
        code_sw = (((r >> 24) % 2) != 0) ? GOOD : 4'($urandom);
        code_enter = 1'b1;
      end else if (code_enter && (r >> 20) % 3 == 0) begin
        code_enter = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
